// File: rtl/rle_pixel_expander.sv
// Run-length pixel expander: turns RUN/REPEAT instructions at the buffer head into one RGB332
// colour per requested pixel, peels off AUDIO samples and drives the buffer-chain shift enable.
module rle_pixel_expander (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] instruction,
  input  logic        instr_valid,
  input  logic        pixel_req,
  output logic [7:0]  rgb_out,
  output logic        rgb_valid,
  output logic        cont_shift,
  output logic [7:0]  audio_sample,
  output logic        audio_strobe,
  output logic        underrun
);

  typedef enum logic [1:0] {
    OpRun    = 2'b00,
    OpRepeat = 2'b01,
    OpAudio  = 2'b10,
    OpNop    = 2'b11
  } op_e;

  op_e         opcode;
  logic        need_load;
  logic        load_run;
  logic        load_audio;

  logic        active_q, active_d;
  logic [7:0]  colour_q, colour_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  audio_q, audio_d;
  logic        strobe_q, strobe_d;
  logic        underrun_q, underrun_d;

  assign opcode = op_e'(instruction[17:16]);

  // Shift is gated by rst_n so the buffer chain never advances while held in reset.
  always_comb begin
    need_load  = !active_q || (pixel_req && (remaining_q == 16'd0));
    cont_shift = rst_n && instr_valid && (instruction[17] || need_load);
    load_run   = cont_shift && (opcode == OpRun || opcode == OpRepeat);
    load_audio = cont_shift && (opcode == OpAudio);
  end

  always_comb begin
    active_d    = active_q;
    colour_d    = colour_q;
    remaining_d = remaining_q;
    audio_d     = audio_q;
    strobe_d    = load_audio;
    underrun_d  = underrun_q | (pixel_req && !active_q);

    if (load_run) begin
      active_d = 1'b1;
      if (opcode == OpRun) begin
        colour_d    = instruction[7:0];
        remaining_d = {8'h00, instruction[15:8]};
      end else begin
        remaining_d = instruction[15:0];
      end
    end else if (pixel_req && active_q) begin
      // Last pixel with nothing loaded ends the run.
      if (remaining_q == 16'd0) begin
        active_d = 1'b0;
      end else begin
        remaining_d = remaining_q - 16'd1;
      end
    end

    if (load_audio) begin
      audio_d = instruction[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      colour_q    <= 8'h00;
      remaining_q <= 16'd0;
      audio_q     <= 8'h80;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      active_q    <= active_d;
      colour_q    <= colour_d;
      remaining_q <= remaining_d;
      audio_q     <= audio_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    rgb_out      = active_q ? colour_q : 8'h00;
    rgb_valid    = active_q;
    audio_sample = audio_q;
    audio_strobe = strobe_q;
    underrun     = underrun_q;
  end

endmodule

// File: tb/tb_rle_pixel_expander.sv
// Bench for rle_pixel_expander: directed scenarios plus random instruction streams, checked
// against a pixel-count reference model of the expander.
module tb_rle_pixel_expander;

  logic        clk;
  logic        rst_n;
  logic [17:0] instruction;
  logic        instr_valid;
  logic        pixel_req;
  logic [7:0]  rgb_out;
  logic        rgb_valid;
  logic        cont_shift;
  logic [7:0]  audio_sample;
  logic        audio_strobe;
  logic        underrun;

  rle_pixel_expander dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pixel_req   (pixel_req),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .cont_shift  (cont_shift),
    .audio_sample(audio_sample),
    .audio_strobe(audio_strobe),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: m_left counts pixels still to show in the current run (0 = no run).
  logic [17:0] q[$];
  int          m_left;
  logic [7:0]  m_colour;
  logic [7:0]  m_audio;
  logic        m_strobe;
  logic        m_underrun;

  logic [7:0]  exp_rgb;
  logic        exp_valid;
  logic        exp_shift;

  task automatic model_reset();
    m_left     = 0;
    m_colour   = 8'h00;
    m_audio    = 8'h80;
    m_strobe   = 1'b0;
    m_underrun = 1'b0;
  endtask

  // Drive inputs (just after a rising edge), then move to the falling edge and predict outputs.
  task automatic sample(input bit req, input bit hold);
    pixel_req   = req;
    instr_valid = (q.size() > 0) && !hold;
    instruction = (q.size() > 0) ? q[0] : 18'h0;
    @(negedge clk);
    exp_valid = (m_left > 0);
    exp_rgb   = (m_left > 0) ? m_colour : 8'h00;
    exp_shift = instr_valid && (instruction[17] || m_left == 0 || (pixel_req && m_left == 1));
  endtask

  task automatic advance();
    if (pixel_req && m_left == 0) m_underrun = 1'b1;
    if (pixel_req && m_left > 0) m_left--;
    m_strobe = 1'b0;
    if (exp_shift) begin
      void'(q.pop_front());
      case (instruction[17:16])
        2'b00: begin
          m_left   = int'(instruction[15:8]) + 1;
          m_colour = instruction[7:0];
        end
        2'b01: m_left = int'(instruction[15:0]) + 1;
        2'b10: begin
          m_audio  = instruction[7:0];
          m_strobe = 1'b1;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({rgb_out, rgb_valid, cont_shift, audio_sample, audio_strobe, underrun} !==
        {8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got rgb=%h v=%b sh=%b aud=%h st=%b ur=%b want 00 0 0 80 0 0",
               rgb_out, rgb_valid, cont_shift, audio_sample, audio_strobe, underrun);
    end
  endtask

  task automatic test_run_run();
    logic [7:0] rgb_log[7];
    logic       val_log[7];
    logic       sh_log[7];
    logic       ur_log[7];
    q.push_back(18'h002E0);
    q.push_back(18'h0001C);
    for (int c = 0; c < 7; c++) begin
      sample(c != 0, 0);
      rgb_log[c] = rgb_out; val_log[c] = rgb_valid; sh_log[c] = cont_shift; ur_log[c] = underrun;
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL run_run c%0d v/rgb/sh got %b/%h/%b want %b/%h/%b", c, rgb_valid,
                 rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      checks++;
      if ({audio_strobe, audio_sample, underrun} !== {m_strobe, m_audio, m_underrun}) begin
        errors++;
        $display("FAIL run_run_aux c%0d got %b/%h/%b want %b/%h/%b", c, audio_strobe,
                 audio_sample, underrun, m_strobe, m_audio, m_underrun);
      end
      advance();
    end
    checks++;
    if ({val_log[1], rgb_log[1], val_log[3], rgb_log[3], val_log[4], rgb_log[4], val_log[5]} !==
        {1'b1, 8'hE0, 1'b1, 8'hE0, 1'b1, 8'h1C, 1'b0}) begin
      errors++;
      $display("FAIL run_run_seq got %h %h %h v5=%b want E0 E0 1C v5=0",
               rgb_log[1], rgb_log[3], rgb_log[4], val_log[5]);
    end
    checks++;
    if ({sh_log[0], sh_log[1], sh_log[3], ur_log[5], ur_log[6]} !== 5'b10101) begin
      errors++;
      $display("FAIL run_run_shift got sh0=%b sh1=%b sh3=%b ur5=%b ur6=%b want 1 0 1 0 1",
               sh_log[0], sh_log[1], sh_log[3], ur_log[5], ur_log[6]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rgb_log[5];
    logic       sh_log[5];
    q.push_back(18'h00003);
    q.push_back(18'h00030);
    q.push_back(18'h000C0);
    for (int c = 0; c < 5; c++) begin
      sample(1, 0);
      rgb_log[c] = rgb_out; sh_log[c] = cont_shift;
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL b2b c%0d v/rgb/sh got %b/%h/%b want %b/%h/%b", c, rgb_valid,
                 rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      advance();
    end
    checks++;
    if ({sh_log[0], sh_log[1], sh_log[2], sh_log[3], rgb_log[1], rgb_log[2], rgb_log[3]} !==
        {4'b1110, 8'h03, 8'h30, 8'hC0}) begin
      errors++;
      $display("FAIL b2b_seq got sh=%b%b%b%b rgb=%h %h %h want 1110 03 30 C0", sh_log[0],
               sh_log[1], sh_log[2], sh_log[3], rgb_log[1], rgb_log[2], rgb_log[3]);
    end
  endtask

  task automatic test_repeat();
    int pixels = 0;
    q.push_back(18'h00003);
    q.push_back(18'h10004);
    for (int c = 0; c < 9; c++) begin
      sample(1, 0);
      if (rgb_valid && rgb_out == 8'h03) pixels++;
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL repeat c%0d v/rgb/sh got %b/%h/%b want %b/%h/%b", c, rgb_valid,
                 rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      advance();
    end
    checks++;
    if (pixels != 6) begin
      errors++;
      $display("FAIL repeat_len got %0d pixels of 03 want 6", pixels);
    end
  endtask

  task automatic test_audio_nop();
    int pixels = 0;
    int strobes = 0;
    q.push_back(18'h0095A);
    for (int c = 0; c < 14; c++) begin
      if (c == 3) begin
        q.push_back(18'h20055);
        q.push_back(18'h30000);
      end
      sample(1, 0);
      if (rgb_valid && rgb_out == 8'h5A) pixels++;
      if (audio_strobe) strobes++;
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL audio c%0d v/rgb/sh got %b/%h/%b want %b/%h/%b", c, rgb_valid,
                 rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      checks++;
      if ({audio_strobe, audio_sample} !== {m_strobe, m_audio}) begin
        errors++;
        $display("FAIL audio_aux c%0d got %b/%h want %b/%h", c, audio_strobe, audio_sample,
                 m_strobe, m_audio);
      end
      advance();
    end
    checks++;
    if (pixels != 10 || strobes != 1 || audio_sample !== 8'h55) begin
      errors++;
      $display("FAIL audio_sum got pix=%0d strobes=%0d aud=%h want 10 1 55", pixels, strobes,
               audio_sample);
    end
  endtask

  task automatic test_blanking();
    int pixels77 = 0;
    int blank_shifts = 0;
    int pixels11 = 0;
    q.push_back(18'h00377);
    for (int c = 0; c < 28; c++) begin
      if (c == 3) q.push_back(18'h00111);
      sample(!(c >= 3 && c < 23), 0);
      if (pixel_req && rgb_valid && rgb_out == 8'h77) pixels77++;
      if (pixel_req && rgb_valid && rgb_out == 8'h11) pixels11++;
      if (!pixel_req && cont_shift) blank_shifts++;
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL blank c%0d v/rgb/sh got %b/%h/%b want %b/%h/%b", c, rgb_valid,
                 rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      advance();
    end
    checks++;
    if (pixels77 != 4 || pixels11 != 2 || blank_shifts != 0) begin
      errors++;
      $display("FAIL blank_sum got p77=%0d p11=%0d bshift=%0d want 4 2 0", pixels77, pixels11,
               blank_shifts);
    end
  endtask

  task automatic test_reset_mid_run();
    logic first_shift;
    q.push_back(18'h0C7AB);
    for (int c = 0; c < 50; c++) begin
      sample(1, 0);
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL rstmid c%0d v/rgb/sh got %b/%h/%b want %b/%h/%b", c, rgb_valid,
                 rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      advance();
    end
    q.push_back(18'h0001C);
    sample(1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rgb_out, rgb_valid, cont_shift, audio_sample, audio_strobe, underrun} !==
        {8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_async got rgb=%h v=%b sh=%b aud=%h st=%b ur=%b want 00 0 0 80 0 0",
               rgb_out, rgb_valid, cont_shift, audio_sample, audio_strobe, underrun);
    end
    model_reset();
    q.delete();
    instr_valid = 1'b0;
    pixel_req   = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      sample(0, 0);
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL rstmid_idle c%0d v/rgb/sh got %b/%h/%b want %b/%h/%b", c, rgb_valid,
                 rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      advance();
    end
    q.push_back(18'h00142);
    first_shift = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample(1, 0);
      if (c == 0) first_shift = cont_shift;
      checks++;
      if ({rgb_valid, rgb_out, cont_shift, underrun} !==
          {exp_valid, exp_rgb, exp_shift, m_underrun}) begin
        errors++;
        $display("FAIL rstmid_after c%0d got %b/%h/%b/%b want %b/%h/%b/%b", c, rgb_valid,
                 rgb_out, cont_shift, underrun, exp_valid, exp_rgb, exp_shift, m_underrun);
      end
      advance();
    end
    checks++;
    if (first_shift !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_head got shift=%b want 1", first_shift);
    end
  endtask

  function automatic logic [17:0] rand_instr();
    int unsigned r;
    logic [7:0]  b0;
    logic [15:0] w;
    r  = $urandom_range(0, 9);
    b0 = 8'($urandom);
    w  = 16'($urandom);
    if (r < 5) return {2'b00, 5'b0, 3'($urandom_range(0, 7)), b0};
    if (r < 7) return {2'b01, 16'($urandom_range(0, 6))};
    if (r < 9) return {2'b10, 8'h00, b0};
    return {2'b11, w};
  endfunction

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      while (q.size() < 3) q.push_back(rand_instr());
      sample($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      checks++;
      if ({rgb_valid, rgb_out, cont_shift} !== {exp_valid, exp_rgb, exp_shift}) begin
        errors++;
        $display("FAIL random c%0d instr=%h v/rgb/sh got %b/%h/%b want %b/%h/%b", c,
                 instruction, rgb_valid, rgb_out, cont_shift, exp_valid, exp_rgb, exp_shift);
      end
      checks++;
      if ({audio_strobe, audio_sample, underrun} !== {m_strobe, m_audio, m_underrun}) begin
        errors++;
        $display("FAIL random_aux c%0d got %b/%h/%b want %b/%h/%b", c, audio_strobe,
                 audio_sample, underrun, m_strobe, m_audio, m_underrun);
      end
      advance();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = 18'h0;
    instr_valid = 1'b0;
    pixel_req   = 1'b0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_run_run();
    test_back_to_back();
    test_repeat();
    test_audio_nop();
    test_blanking();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
